// File: rtl/img_ram_arbiter_if.sv
// Request/grant bus between the host and processor requesters, the image RAM
// arbiter and the single-port image RAM.
interface img_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
);
  logic                  h_req;
  logic                  h_we;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic                  h_gnt;
  logic                  h_rvalid;

  logic                  p_req;
  logic                  p_we;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_wdata;
  logic                  p_gnt;
  logic                  p_rvalid;

  logic                  proc_run;
  logic [DATA_WIDTH-1:0] rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Arbiter side
  modport slave (
    input  h_req, h_we, h_addr, h_wdata,
    input  p_req, p_we, p_addr, p_wdata,
    input  proc_run, ram_dout,
    output h_gnt, h_rvalid, p_gnt, p_rvalid, rdata,
    output ram_addr, ram_we, ram_din
  );

  // Requester and RAM side
  modport master (
    output h_req, h_we, h_addr, h_wdata,
    output p_req, p_we, p_addr, p_wdata,
    output proc_run, ram_dout,
    input  h_gnt, h_rvalid, p_gnt, p_rvalid, rdata,
    input  ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/img_ram_arbiter.sv
// Two-requester (host/processor) arbiter for a single-port synchronous image RAM.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is processor-first.
module img_ram_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  img_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e                state_q;
  logic                  owner_q;   // 1: host owns the in-flight access
  logic                  op_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_we_q;
  logic [DATA_WIDTH-1:0] ram_din_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  h_rvalid_q;
  logic                  p_rvalid_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  prio_host_q; // 1: host wins the next tie
`endif

  logic                  h_elig;
  logic                  h_win;
  logic                  p_win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    h_elig    = bus.h_req & ~bus.proc_run;
`ifdef ARB_ROUND_ROBIN_EN
    h_win     = h_elig & (~bus.p_req | prio_host_q);
`else
    h_win     = h_elig & ~bus.p_req;
`endif
    p_win     = bus.p_req & ~h_win;
    sel_we    = bus.p_we;
    sel_addr  = bus.p_addr;
    sel_wdata = bus.p_wdata;
    if (h_win) begin
      sel_we    = bus.h_we;
      sel_addr  = bus.h_addr;
      sel_wdata = bus.h_wdata;
    end
  end

  // Grant is a same-cycle acceptance of the held request while IDLE; it is
  // gated by reset so nothing is accepted while the block is held in reset.
  assign bus.h_gnt    = rst & (state_q == IDLE) & h_win;
  assign bus.p_gnt    = rst & (state_q == IDLE) & p_win;
  assign bus.h_rvalid = h_rvalid_q;
  assign bus.p_rvalid = p_rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_din  = ram_din_q;

  // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      op_we_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      rdata_q     <= '0;
      h_rvalid_q  <= 1'b0;
      p_rvalid_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_host_q <= 1'b0;
`endif
    end else begin
      h_rvalid_q <= 1'b0;
      p_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (h_win | p_win) begin
            owner_q     <= h_win;
            op_we_q     <= sel_we;
            ram_addr_q  <= sel_addr;
            ram_we_q    <= sel_we;
            ram_din_q   <= sel_wdata;
            state_q     <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            prio_host_q <= ~h_win;
`endif
          end
        end
        ACCESS: begin
          ram_we_q <= 1'b0;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          // RAM output is valid this cycle; writes capture it too but never signal rvalid.
          rdata_q    <= bus.ram_dout;
          h_rvalid_q <= owner_q & ~op_we_q;
          p_rvalid_q <= ~owner_q & ~op_we_q;
          state_q    <= IDLE;
        end
        default: begin
          ram_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_ram_arbiter.sv
// Self-checking bench for img_ram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model of grants, RAM writes and read-backs.
module tb_img_ram_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  img_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  img_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous read-first RAM
  logic [DW-1:0] ram [0:31];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr[4:0]] <= bus.ram_din;
    bus.ram_dout <= ram[bus.ram_addr[4:0]];
  end

  // Requester state
  bit            hr, hw, pr, pw, run;
  logic [AW-1:0] ha, pa;
  logic [DW-1:0] hd, pd;
  bit            h_gnt_seen, p_gnt_seen;

  // Reference model: one access in flight, grants spaced 3 cycles apart,
  // RAM write at grant+1, read data returned at grant+3.
  int            cyc;
  int            last_gnt;
  bit            last_host;
  bit            t_host, t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data;
  logic [DW-1:0] mdl_mem [0:31];

  int checks;
  int failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    last_gnt   = -100;
    last_host  = 1'b1;
    t_host     = 1'b0;
    t_we       = 1'b0;
    t_addr     = '0;
    t_data     = '0;
    h_gnt_seen = 1'b0;
    p_gnt_seen = 1'b0;
  endtask

  task automatic step();
    bit free, h_el, exp_hg, exp_pg;
    @(posedge clk);
    #1;
    bus.h_req = hr; bus.h_we = hw; bus.h_addr = ha; bus.h_wdata = hd;
    bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd;
    bus.proc_run = run;
    cyc++;
    @(negedge clk);
    free   = (cyc - last_gnt) >= 3;
    h_el   = hr && !run;
    exp_hg = 1'b0;
    exp_pg = 1'b0;
    if (free) begin
      if (h_el && pr) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_host) exp_pg = 1'b1;
        else           exp_hg = 1'b1;
`else
        exp_pg = 1'b1;
`endif
      end else begin
        exp_hg = h_el;
        exp_pg = pr;
      end
    end
    check("h_gnt", bus.h_gnt, exp_hg);
    check("p_gnt", bus.p_gnt, exp_pg);
    check("ram_we", bus.ram_we, (cyc == last_gnt + 1) && t_we);
    if (cyc == last_gnt + 1) begin
      check("ram_addr", bus.ram_addr, t_addr);
      if (t_we) check("ram_din", bus.ram_din, t_data);
    end
    check("h_rvalid", bus.h_rvalid, (cyc == last_gnt + 3) && !t_we && t_host);
    check("p_rvalid", bus.p_rvalid, (cyc == last_gnt + 3) && !t_we && !t_host);
    if ((cyc == last_gnt + 3) && !t_we) check("rdata", bus.rdata, t_data);
    if (exp_hg || exp_pg) begin
      last_gnt  = cyc;
      last_host = exp_hg;
      t_host    = exp_hg;
      t_we      = exp_hg ? hw : pw;
      t_addr    = exp_hg ? ha : pa;
      if (t_we) begin
        t_data               = exp_hg ? hd : pd;
        mdl_mem[t_addr[4:0]] = t_data;
      end else begin
        t_data = mdl_mem[t_addr[4:0]];
      end
    end
    h_gnt_seen = bus.h_gnt;
    p_gnt_seen = bus.p_gnt;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_ram_addr", bus.ram_addr, '0);
    check("rst_ram_din", bus.ram_din, '0);
    check("rst_rdata", bus.rdata, '0);
    check("rst_gnt", {bus.h_gnt, bus.p_gnt}, 2'b00);
    check("rst_rvalid", {bus.h_rvalid, bus.p_rvalid}, 2'b00);
    hr = 0; pr = 0;
    bus.h_req = 1'b0; bus.p_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hold_rvalid", {bus.h_rvalid, bus.p_rvalid}, 2'b00);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic wait_host_gnt(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      got = h_gnt_seen;
    end
    check(tag, got, 1'b1);
  endtask

  task automatic wait_proc_gnt(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      got = p_gnt_seen;
    end
    check(tag, got, 1'b1);
  endtask

  initial begin
    logic [3:0] order, exp_order;
    int         n_gnt, h_cnt;

    checks = 0; failures = 0; cyc = 0;
    for (int i = 0; i < 32; i++) begin
      ram[i]     = DW'(i * 7 + 3);
      mdl_mem[i] = DW'(i * 7 + 3);
    end
    hr = 0; hw = 0; ha = '0; hd = '0;
    pr = 0; pw = 0; pa = '0; pd = '0; run = 0;
    bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
    bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.proc_run = 0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("por_ram_we", bus.ram_we, 1'b0);
    check("por_rdata", bus.rdata, '0);
    check("por_ram_addr", bus.ram_addr, '0);
    rst = 1'b1;

    // Host write 0xA5 to 0x10
    hr = 1; hw = 1; ha = AW'(16); hd = 8'hA5;
    wait_host_gnt("s31_h_gnt");
    hr = 0;
    repeat (4) step();

    // Processor read of 0x10
    pr = 1; pw = 0; pa = AW'(16);
    wait_proc_gnt("s32_p_gnt");
    pr = 0;
    repeat (4) step();
    check("s32_rdata_hold", bus.rdata, 8'hA5);

    // Tie-break order over four grants, starting from reset pointer
    do_reset();
    hr = 1; hw = 0; ha = AW'(3);
    pr = 1; pw = 0; pa = AW'(5);
    order = '0; n_gnt = 0;
    for (int k = 0; k < 20 && n_gnt < 4; k++) begin
      step();
      if (h_gnt_seen || p_gnt_seen) begin
        order[n_gnt] = h_gnt_seen;
        n_gnt++;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    check("s33_count", n_gnt, 4);
    check("s33_order", order, exp_order);
    hr = 0; pr = 0;
    repeat (4) step();

    // Host locked out while the processor runs
    run = 1; hr = 1; hw = 0; ha = AW'(16);
    h_cnt = 0;
    repeat (10) begin
      step();
      if (h_gnt_seen) h_cnt++;
    end
    check("s34_locked", h_cnt, 0);
    run = 0;
    step();
    check("s34_release", h_gnt_seen, 1'b1);
    hr = 0;
    repeat (4) step();

    // Reset during ACCESS of a processor read, with both requests held
    pr = 1; pw = 0; pa = AW'(16); hr = 1;
    wait_proc_gnt("s35_p_gnt");
    hr = 1; pr = 1;
    do_reset();
    repeat (4) step();
    check("s35_rdata", bus.rdata, '0);
    pr = 1; pw = 0; pa = AW'(7);
    step();
    check("s35_first_gnt", p_gnt_seen, 1'b1);
    pr = 0;
    repeat (4) step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!hr || h_gnt_seen) begin
        hr = ($urandom_range(0, 2) != 0);
        hw = $urandom_range(0, 1);
        ha = AW'($urandom_range(0, 31));
        hd = DW'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        hr = 0;
      end
      if (!pr || p_gnt_seen) begin
        pr = ($urandom_range(0, 2) != 0);
        pw = $urandom_range(0, 1);
        pa = AW'($urandom_range(0, 31));
        pd = DW'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        pr = 0;
      end
      if ($urandom_range(0, 19) == 0) run = !run;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/img_ram_arbiter.md
IMG_RAM_ARBITER -- requirements
Module: img_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 19, meaning image RAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning image RAM data width.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 The block SHALL have ports h_req / p_req, inputs, 1 bit each, meaning a host (UART) or processor access request.
REQ-006 The block SHALL have ports h_we / p_we, inputs, 1 bit each, meaning the request is a write (1) or a read (0).
REQ-007 The block SHALL have ports h_addr / p_addr, inputs, ADDR_WIDTH bits each, meaning the access address.
REQ-008 The block SHALL have ports h_wdata / p_wdata, inputs, DATA_WIDTH bits each, meaning the write data.
REQ-009 The block SHALL have ports h_gnt / p_gnt, outputs, 1 bit each, meaning a 1-cycle pulse that accepts the request.
REQ-010 The block SHALL have ports h_rvalid / p_rvalid, outputs, 1 bit each, meaning a 1-cycle pulse marking read data valid.
REQ-011 The block SHALL have port rdata, output, DATA_WIDTH bits, meaning the captured RAM read data.
REQ-012 The block SHALL have port proc_run, input, 1 bit, meaning the processor is running; the host is locked out.
REQ-013 The block SHALL have ports ram_addr (ADDR_WIDTH bits), ram_we (1 bit) and ram_din (DATA_WIDTH bits), all outputs and registered, driving the single-port RAM.
REQ-014 The block SHALL have port ram_dout, input, DATA_WIDTH bits, meaning synchronous RAM read data, valid one cycle after the address.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and CAPTURE, and SHALL be in IDLE after reset.
REQ-016 In IDLE with an eligible request at edge N, the block SHALL:
- pulse the winner's gnt in cycle N;
- load ram_addr, ram_we and ram_din with the winner's values at edge N+1;
- enter ACCESS.
REQ-017 ACCESS SHALL clear ram_we at the next edge (the write pulse lasts exactly 1 cycle) and go to CAPTURE.
REQ-018 CAPTURE SHALL register ram_dout into rdata, pulse the owner's rvalid for reads only (never for writes), and return to IDLE.
REQ-019 Read latency SHALL be gnt at cycle N to rvalid at cycle N+3, and the minimum spacing between grants SHALL be 3 cycles.
REQ-020 Requests SHALL be level-held by the requester until gnt; a request dropped before gnt SHALL be ignored with no RAM access.
REQ-021 While proc_run=1 the host request SHALL be ineligible; h_gnt SHALL stay 0 and h_req SHALL remain pending.
REQ-022 proc_run rising mid-transaction SHALL NOT abort an in-flight host access; it completes normally.
REQ-023 With simultaneous eligible requests, the winner SHALL be chosen per REQ-029/REQ-030.
REQ-024 The registered owner bit SHALL select which rvalid pulses; rdata SHALL hold its value until the next CAPTURE.
REQ-025 No state other than IDLE SHALL issue a gnt; an undefined state SHALL return to IDLE.

Reset
REQ-026 Assertion of rst=0 SHALL asynchronously force:
- state to IDLE;
- all gnt, rvalid and ram_we to 0;
- ram_addr, ram_din and rdata to 0;
- the priority pointer to processor.
REQ-027 Reset asserted mid-ACCESS SHALL drop ram_we immediately; no rvalid SHALL follow.
REQ-028 After reset deasserts, the first eligible request SHALL be granted per REQ-016.

Configuration
REQ-029 With macro ARB_ROUND_ROBIN_EN defined, ties SHALL alternate: the last-granted requester loses the next tie.
REQ-030 Without ARB_ROUND_ROBIN_EN, ties SHALL always go to the processor (fixed priority).

Verification
REQ-031 Scenario: host write, addr 0x00010, data 0xA5, proc_run=0 -> h_gnt in cycle N; ram_we=1 for exactly 1 cycle at N+1 with addr 0x00010 and din 0xA5; no h_rvalid.
REQ-032 Scenario: processor read of addr 0x00010 after REQ-031 -> p_rvalid at N+3 with rdata=0xA5; h_rvalid stays 0.
REQ-033 Scenario: h_req and p_req held together for 4 grants -> with the macro, grant order P,H,P,H; without it, P,P,P,P while p_req stays held.
REQ-034 Scenario: proc_run=1 and h_req held 10 cycles -> zero h_gnt; after proc_run falls, h_gnt within 1 cycle in IDLE.
REQ-035 Scenario: rst pulsed low during ACCESS of a processor read -> ram_we=0 immediately, no p_rvalid, FSM in IDLE, rdata=0.
